// File: rtl/agu_stage_scheduler_if.sv
// AGU stage scheduler handshake bundle.
// Control inputs and AGU enable/status outputs.
interface agu_stage_scheduler_if;
  logic       start;
  logic       abort;
  logic       agu_done;
  logic       AGU_enable;
  logic       AGU_enable_k2;
  logic       LAST_STAGE;
  logic [2:0] stage_idx;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    input  start,
    input  abort,
    input  agu_done,
    output AGU_enable,
    output AGU_enable_k2,
    output LAST_STAGE,
    output stage_idx,
    output busy,
    output done,
    output error
  );

  modport slave (
    output start,
    output abort,
    output agu_done,
    input  AGU_enable,
    input  AGU_enable_k2,
    input  LAST_STAGE,
    input  stage_idx,
    input  busy,
    input  done,
    input  error
  );
endinterface

// File: rtl/agu_stage_scheduler.sv
// Sequences K1_STAGES radix-16 AGU passes, a gap cycle
// between passes, one k2 pass, with a per-stage watchdog.
module agu_stage_scheduler #(
  parameter int K1_STAGES = 3,
  parameter int TIMEOUT   = 1023
) (
  input logic clk,
  input logic rst,
  agu_stage_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, K1, GAP, K2, FIN, ERR
  } state_t;

  localparam logic [2:0]  LAST_K1 = 3'(K1_STAGES - 1);
  localparam logic [2:0]  K2_IDX  = 3'(K1_STAGES);
  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [2:0]  idx_nxt;
  logic        last_nxt;

  // Next state, watchdog count, stage index and mux select.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bus.stage_idx;
    last_nxt  = bus.LAST_STAGE;
    if (bus.abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      last_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state_nxt = K1;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            last_nxt  = 1'b0;
          end
        end
        K1: begin
          if (bus.agu_done) begin
            state_nxt = GAP;
            last_nxt  = (bus.stage_idx == LAST_K1);
          end else if (cnt == TO_LIM) begin
            state_nxt = ERR;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            last_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        GAP: begin
          cnt_nxt = '0;
          if (bus.stage_idx < LAST_K1) begin
            state_nxt = K1;
            idx_nxt   = bus.stage_idx + 3'd1;
          end else begin
            state_nxt = K2;
            idx_nxt   = K2_IDX;
            last_nxt  = 1'b1;
          end
        end
        K2: begin
          if (bus.agu_done) begin
            state_nxt = FIN;
          end else if (cnt == TO_LIM) begin
            state_nxt = ERR;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            last_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        FIN: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          last_nxt  = 1'b0;
        end
        ERR: begin
          state_nxt = ERR;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          last_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs decoded from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.AGU_enable    <= 1'b0;
      bus.AGU_enable_k2 <= 1'b0;
      bus.LAST_STAGE    <= 1'b0;
      bus.stage_idx     <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.error         <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      bus.AGU_enable    <= (state_nxt == K1);
      bus.AGU_enable_k2 <= (state_nxt == K2);
      bus.LAST_STAGE    <= last_nxt;
      bus.stage_idx     <= idx_nxt;
      bus.busy          <= (state_nxt != IDLE)
                           && (state_nxt != ERR);
      bus.done          <= (state_nxt == FIN);
      bus.error         <= (state_nxt == ERR);
    end
  end

endmodule

// File: tb/tb_agu_stage_scheduler.sv
// Bench for agu_stage_scheduler: scenario tasks with a
// queue of expected per-cycle output vectors.
module tb_agu_stage_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;

  agu_stage_scheduler_if bus();

  agu_stage_scheduler #(
    .K1_STAGES(3),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [8:0] q[$];

  // {en, en2, last, idx[2:0], busy, done, error}
  function automatic logic [8:0] v(
    input logic en, input logic en2, input logic last,
    input logic [2:0] idx, input logic bsy,
    input logic dn, input logic er);
    return {en, en2, last, idx, bsy, dn, er};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.AGU_enable, bus.AGU_enable_k2,
            bus.LAST_STAGE, bus.stage_idx,
            bus.busy, bus.done, bus.error};
  endfunction

  // Nominal timeline, start at cycle 0, done 5 cycles per stage.
  function automatic logic [8:0] nom(input int c);
    logic en, en2, last, bsy, dn;
    logic [2:0] idx;
    en  = (c >= 1 && c <= 5) || (c >= 7 && c <= 11)
          || (c >= 13 && c <= 17);
    en2 = (c >= 19 && c <= 23);
    last = (c >= 18 && c <= 24);
    bsy = (c >= 1 && c <= 24);
    dn  = (c == 24);
    if (c >= 1 && c <= 6)        idx = 3'd0;
    else if (c >= 7 && c <= 12)  idx = 3'd1;
    else if (c >= 13 && c <= 18) idx = 3'd2;
    else if (c >= 19 && c <= 24) idx = 3'd3;
    else                         idx = 3'd0;
    return v(en, en2, last, idx, bsy, dn, 1'b0);
  endfunction

  function automatic logic nom_done(input int c);
    return (c <= 23) && (c % 6 == 5);
  endfunction

  task automatic test_reset();
    logic [8:0] e, g;
    bus.start = 0; bus.abort = 0; bus.agu_done = 0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.start = (c == 1);
      q.push_back(9'd0);
      @(posedge clk); #1;
      e = q.pop_front(); g = obs(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL reset_hold c=%0d got=%b exp=%b", c, g, e);
      end
    end
    bus.start = 0;
    rst = 1'b1;
    q.push_back(9'd0);
    @(posedge clk); #1;
    e = q.pop_front(); g = obs(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL reset_release got=%b exp=%b", g, e);
    end
  endtask

  task automatic test_nominal(input string nm, input int last_c);
    logic [8:0] e, g;
    logic pd;
    pd = 1'b0;
    for (int c = 0; c <= last_c; c++) begin
      bus.start = (c == 0); bus.abort = 0;
      bus.agu_done = nom_done(c);
      q.push_back(nom(c + 1));
      @(posedge clk); #1;
      e = q.pop_front(); g = obs(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s c=%0d got=%b exp=%b", nm, c + 1, g, e);
      end
      tests++;
      if ((g[8] & g[7]) || (g[1] & pd)) begin
        fails++;
        $display("FAIL %s_inv c=%0d got=%b", nm, c + 1, g);
      end
      pd = g[1];
    end
    bus.agu_done = 0;
  endtask

  task automatic test_timeout();
    logic [8:0] e, g, x;
    for (int c = 0; c <= 21; c++) begin
      int t;
      t = c + 1;
      bus.start = (c == 0) || (c == 18);
      bus.abort = (c == 20);
      bus.agu_done = 0;
      if (t <= 16)      x = v(1, 0, 0, 3'd0, 1, 0, 0);
      else if (t <= 20) x = v(0, 0, 0, 3'd0, 0, 0, 1);
      else              x = 9'd0;
      q.push_back(x);
      @(posedge clk); #1;
      e = q.pop_front(); g = obs(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL timeout c=%0d got=%b exp=%b", t, g, e);
      end
    end
    bus.abort = 0;
  endtask

  task automatic test_abort_k2();
    logic [8:0] e, g;
    for (int c = 0; c <= 23; c++) begin
      bus.start = (c == 0);
      bus.abort = (c == 21);
      bus.agu_done = nom_done(c) || (c == 21);
      q.push_back((c + 1 <= 21) ? nom(c + 1) : 9'd0);
      @(posedge clk); #1;
      e = q.pop_front(); g = obs(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL abort_k2 c=%0d got=%b exp=%b", c + 1, g, e);
      end
    end
    bus.abort = 0; bus.agu_done = 0;
  endtask

  task automatic test_repulse();
    logic [8:0] e, g;
    for (int c = 0; c <= 26; c++) begin
      bus.start = (c == 0) || (c == 8) || (c == 18)
                  || (c == 24);
      bus.abort = 0;
      bus.agu_done = nom_done(c) || (c == 6) || (c == 12)
                     || (c == 24) || (c == 25);
      q.push_back(nom(c + 1));
      @(posedge clk); #1;
      e = q.pop_front(); g = obs(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL repulse c=%0d got=%b exp=%b", c + 1, g, e);
      end
    end
    bus.start = 0; bus.agu_done = 0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] e, g;
    for (int c = 0; c <= 14; c++) begin
      bus.start = (c == 0); bus.abort = 0;
      bus.agu_done = nom_done(c);
      q.push_back(nom(c + 1));
      @(posedge clk); #1;
      e = q.pop_front(); g = obs(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL reset_mid_pre c=%0d got=%b exp=%b", c + 1, g, e);
      end
    end
    bus.start = 0; bus.agu_done = 0;
    #2 rst = 1'b0;
    #1;
    q.push_back(9'd0);
    e = q.pop_front(); g = obs(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL reset_async got=%b exp=%b", g, e);
    end
    @(posedge clk); #1;
    #3 rst = 1'b1;
    q.push_back(9'd0);
    @(posedge clk); #1;
    e = q.pop_front(); g = obs(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL reset_mid_idle got=%b exp=%b", g, e);
    end
    test_nominal("reset_rerun", 25);
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.agu_done = 0;
    test_reset();
    test_nominal("nominal", 26);
    test_timeout();
    test_abort_k2();
    test_repulse();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
